// File: rtl/ioctl_ram_loader.sv
// ioctl_ram_loader: packs HPS halfword downloads into 32-bit words, queues them and writes them over a req/ack port.
// Optional feature macro LOADER_CHECKSUM_EN adds a running checksum of accepted words.
module ioctl_ram_loader #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [31:0] ioctl_dout,
  input  logic [3:0]  ioctl_sel,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        load_done,
  output logic        overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t        state_q, state_d;
  logic          dl_q, dl_d, flush_q, flush_d, armed_q, armed_d;
  logic          pend_valid_q, pend_valid_d;
  logic [22:0]   pend_addr_q, pend_addr_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_be_q, pend_be_d;
  logic [22:0]   fa_q [DEPTH];
  logic [22:0]   fa_d [DEPTH];
  logic [31:0]   fd_q [DEPTH];
  logic [31:0]   fd_d [DEPTH];
  logic [3:0]    fb_q [DEPTH];
  logic [3:0]    fb_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, nxt_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          ioctl_wait_q, ioctl_wait_d, mem_req_q, mem_req_d;
  logic [24:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_din_q, mem_din_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          load_done_q, load_done_d, overflow_q, overflow_d;
  logic          rise, fall, push, do_push, pop;
  logic [22:0]   push_addr;
  logic [31:0]   push_data, merge_data;
  logic [3:0]    push_be, merge_be;

  // Halfword alignment bits carry no information; lane choice comes from ioctl_sel.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ioctl_addr[1:0];

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;
  assign checksum = checksum_q;

  function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
    return r;
  endfunction
`endif

  assign ioctl_wait = ioctl_wait_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_be     = mem_be_q;
  assign load_done  = load_done_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d      = state_q;
    dl_d         = ioctl_download;
    flush_d      = flush_q;
    armed_d      = armed_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_be_d    = pend_be_q;
    fa_d         = fa_q;
    fd_d         = fd_q;
    fb_d         = fb_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_be_d     = mem_be_q;
    overflow_d   = overflow_q;
    load_done_d  = 1'b0;
    push         = 1'b0;
    push_addr    = pend_addr_q;
    push_data    = pend_data_q;
    push_be      = pend_be_q;
    rise         = ioctl_download & ~dl_q;
    fall         = ~ioctl_download & dl_q;
    nxt_ptr      = rd_ptr_q + AW'(1);
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    for (int i = 0; i < 4; i++)
      merge_data[8*i +: 8] = ioctl_sel[i] ? ioctl_dout[8*i +: 8] : pend_data_q[8*i +: 8];
    merge_be = pend_be_q | ioctl_sel;

    // Halfword packing; a flush waits for a cycle without a write so only one push happens.
    if (ioctl_wr) begin
      if (pend_valid_q && ioctl_addr[24:2] == pend_addr_q) begin
        if (merge_be == 4'hF) begin
          push         = 1'b1;
          push_data    = merge_data;
          push_be      = merge_be;
          pend_valid_d = 1'b0;
        end else begin
          pend_data_d = merge_data;
          pend_be_d   = merge_be;
        end
      end else begin
        push         = pend_valid_q;
        pend_valid_d = 1'b1;
        pend_addr_d  = ioctl_addr[24:2];
        pend_data_d  = ioctl_dout;
        pend_be_d    = ioctl_sel;
      end
    end else if (flush_q) begin
      flush_d      = 1'b0;
      push         = pend_valid_q;
      pend_valid_d = 1'b0;
    end

    if (fall) begin
      flush_d = 1'b1;
      armed_d = 1'b1;
    end
    if (rise) begin
      armed_d    = 1'b0;
      overflow_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_d = 32'h0;
`endif
    end

    // FIFO: a push into a full FIFO is allowed only when the head pops in the same cycle.
    pop     = (state_q == ST_REQ) && mem_ack;
    do_push = push && ((count_q != CW'(DEPTH)) || pop);
    if (push && !do_push) overflow_d = 1'b1;
    if (do_push) begin
      fa_d[wr_ptr_q] = push_addr;
      fd_d[wr_ptr_q] = push_data;
      fb_d[wr_ptr_q] = push_be;
      wr_ptr_d       = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = nxt_ptr;
    count_d = count_q + CW'(do_push) - CW'(pop);

    case (state_q)
      ST_IDLE: begin
        if (count_q != CW'(0)) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {fa_q[rd_ptr_q], 2'b00};
          mem_din_d  = fd_q[rd_ptr_q];
          mem_be_d   = fb_q[rd_ptr_q];
          state_d    = ST_REQ;
        end
      end
      default: begin
        if (mem_ack) begin
`ifdef LOADER_CHECKSUM_EN
          checksum_d = (rise ? 32'h0 : checksum_q) + lane_mask(mem_din_q, mem_be_q);
`endif
          if (count_q > CW'(1)) begin
            mem_addr_d = {fa_q[nxt_ptr], 2'b00};
            mem_din_d  = fd_q[nxt_ptr];
            mem_be_d   = fb_q[nxt_ptr];
          end else begin
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
    endcase

    ioctl_wait_d = count_q >= CW'(DEPTH - 2);

    if (armed_q && !rise && !flush_q && !pend_valid_q && count_q == CW'(0) && !mem_req_q) begin
      load_done_d = 1'b1;
      armed_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dl_q         <= 1'b0;
      flush_q      <= 1'b0;
      armed_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_be_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ioctl_wait_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_be_q     <= '0;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      flush_q      <= flush_d;
      armed_q      <= armed_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_be_q    <= pend_be_d;
      fa_q         <= fa_d;
      fd_q         <= fd_d;
      fb_q         <= fb_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ioctl_wait_q <= ioctl_wait_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_be_q     <= mem_be_d;
      load_done_q  <= load_done_d;
      overflow_q   <= overflow_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_ioctl_ram_loader.sv
// Scoreboard bench for ioctl_ram_loader: word-level expectations queued at stimulus time, checked by a memory-port monitor.
// Checksum checks are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_ioctl_ram_loader;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [31:0] ioctl_dout = '0;
  logic [3:0]  ioctl_sel = '0;
  logic        ioctl_wait, mem_req, load_done, overflow;
  logic [24:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  ioctl_ram_loader #(.DEPTH(DEPTH)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_sel(ioctl_sel), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .mem_ack(mem_ack),
    .load_done(load_done), .overflow(overflow)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [24:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0, checks = 0, done_pulses = 0;
  bit          ack_en = 1'b0, wait_seen = 1'b0;
  int unsigned ack_pct = 100;
  logic [31:0] model_sum = '0;
  logic        prev_req = 1'b0, prev_acc = 1'b0;
  logic [60:0] prev_bus = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
    return r;
  endfunction

  // Memory-side responder: random acks while requested, occasional stray acks while idle.
  always @(posedge clk) begin
    #1;
    if (!ack_en) mem_ack = 1'b0;
    else if (mem_req) mem_ack = ($urandom_range(99) < ack_pct);
    else mem_ack = ($urandom_range(9) == 0);
  end

  // Monitor: pops the scoreboard on every accepted write and checks request stability.
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      prev_req = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (ioctl_wait) wait_seen = 1'b1;
      if (load_done) done_pulses++;
      if (mem_req && prev_req && !prev_acc)
        check("req_stable", {3'b0, mem_addr, mem_din, mem_be}, {3'b0, prev_bus});
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h din %h be %h expected none", mem_addr, mem_din, mem_be);
        end else begin
          e = exp_q.pop_front();
          check("mem_write", {3'b0, mem_addr, mem_din, mem_be}, {3'b0, e.addr, e.din, e.be});
          model_sum += lane_mask(e.din, e.be);
        end
      end
      prev_req = mem_req;
      prev_acc = mem_req && mem_ack;
      prev_bus = {mem_addr, mem_din, mem_be};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hw_write(input logic [24:0] a, input logic [15:0] h, input bit hi, input bit respect);
    int n;
    n = 0;
    if (respect) while (ioctl_wait && n < 400) begin step(); n++; end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: got ioctl_wait stuck for %0d cycles expected release", n);
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = a + (hi ? 25'd2 : 25'd0);
    ioctl_dout = {h, h};
    ioctl_sel  = hi ? 4'hC : 4'h3;
    step();
    ioctl_wr = 1'b0;
    repeat ($urandom_range(1)) step();
  endtask

  // mode 0: low then high, 1: high then low, 2: low half only, 3: high half only
  task automatic send_word(input logic [24:0] wa, input logic [31:0] d, input int mode,
                           input bit respect, input bit expect_it);
    wr_t e;
    e.addr = wa;
    case (mode)
      0: begin hw_write(wa, d[15:0], 1'b0, respect); hw_write(wa, d[31:16], 1'b1, respect); end
      1: begin hw_write(wa, d[31:16], 1'b1, respect); hw_write(wa, d[15:0], 1'b0, respect); end
      2: hw_write(wa, d[15:0], 1'b0, respect);
      default: hw_write(wa, d[31:16], 1'b1, respect);
    endcase
    case (mode)
      0, 1:    begin e.din = d;                    e.be = 4'hF; end
      2:       begin e.din = {d[15:0], d[15:0]};   e.be = 4'h3; end
      default: begin e.din = {d[31:16], d[31:16]}; e.be = 4'hC; end
    endcase
    if (expect_it) exp_q.push_back(e);
  endtask

  task automatic start_dl();
    model_sum      = '0;
    ioctl_download = 1'b1;
    step();
    step();
  endtask

  task automatic end_dl();
    int d0, n;
    d0 = done_pulses;
    n  = 0;
    ioctl_download = 1'b0;
    while (done_pulses == d0 && n < 3000) begin step(); n++; end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL load_done_timeout: got no pulse in %0d cycles expected one", n);
    end
    repeat (10) step();
    check("load_done_once", 64'(done_pulses - d0), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_model", {32'h0, checksum}, {32'h0, model_sum});
`endif
  endtask

  initial begin
    int seen, nw, n;
    logic [24:0] wa;
    repeat (3) step();
    check("reset_outputs", {3'b0, mem_req, ioctl_wait, load_done, overflow, mem_addr, mem_din},
          64'd0);
    check("reset_be", {60'd0, mem_be}, 64'd0);
`ifdef LOADER_CHECKSUM_EN
    check("reset_checksum", {32'h0, checksum}, 64'd0);
`endif
    reset = 1'b0;
    step();

    // Two halves of one word with immediate acks
    ack_en = 1'b1; ack_pct = 100;
    start_dl();
    send_word(25'h400000, 32'hABCD1234, 0, 1'b1, 1'b1);
    end_dl();

    // Lone low half flushed at download end
    start_dl();
    send_word(25'h400004, 32'h00005555, 2, 1'b1, 1'b1);
    end_dl();

    // Memory stalled for 50 cycles during a streaming download
    start_dl();
    ack_en = 1'b0;
    wait_seen = 1'b0;
    fork
      begin repeat (50) @(posedge clk); ack_en = 1'b1; end
    join_none
    send_word(25'h400010, $urandom, 0, 1'b1, 1'b1);
    send_word(25'h400014, $urandom, 1, 1'b1, 1'b1);
    repeat (2) step();
    check("wait_at_threshold", {63'd0, ioctl_wait}, 64'd1);
    for (int i = 2; i < 8; i++) send_word(25'h400010 + 25'(4 * i), $urandom, i % 2, 1'b1, 1'b1);
    end_dl();
    check("wait_seen", {63'd0, wait_seen}, 64'd1);
    check("no_overflow_stall", {63'd0, overflow}, 64'd0);

    // Forced overflow: five full words into a four-entry FIFO with acks off
    start_dl();
    ack_en = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 5; i++) send_word(25'h400100 + 25'(4 * i), $urandom, 0, 1'b0, i < 4);
    repeat (3) step();
    check("overflow_set", {63'd0, overflow}, 64'd1);
    check("head_unchanged", {38'd0, mem_req, mem_addr}, {38'd0, 1'b1, 25'h400100});
    ack_en = 1'b1;
    end_dl();
    check("overflow_sticky", {63'd0, overflow}, 64'd1);
    start_dl();
    check("overflow_cleared", {63'd0, overflow}, 64'd0);
    end_dl();

    // Reset while a request is outstanding
    start_dl();
    ack_en = 1'b0;
    send_word(25'h400200, 32'hDEADBEEF, 0, 1'b1, 1'b0);
    n = 0;
    while (!mem_req && n < 50) begin step(); n++; end
    check("req_before_reset", {63'd0, mem_req}, 64'd1);
    reset = 1'b1;
    step();
    check("req_dropped_by_reset", {63'd0, mem_req}, 64'd0);
    ioctl_download = 1'b0;
    step();
    reset     = 1'b0;
    model_sum = '0;
    ack_en    = 1'b1;
    n         = done_pulses;
    seen      = 0;
    repeat (30) begin step(); if (mem_req) seen++; end
    check("fifo_empty_after_reset", 64'(seen), 64'd0);
    check("no_done_after_reset", 64'(done_pulses - n), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    check("checksum_after_reset", {32'h0, checksum}, 64'd0);
`endif

    // Randomized downloads with random word shapes and ack rates
    for (int d = 0; d < 6; d++) begin
      ack_pct = (d % 3 == 0) ? 30 : ((d % 3 == 1) ? 70 : 100);
      start_dl();
      nw = 1 + int'($urandom_range(11));
      wa = 25'h400000;
      for (int i = 0; i < nw; i++) begin
        send_word(wa, $urandom, int'($urandom_range(3)), 1'b1, 1'b1);
        wa = wa + 25'(4 * (1 + $urandom_range(2)));
      end
      end_dl();
      check("no_overflow_random", {63'd0, overflow}, 64'd0);
    end

`ifdef LOADER_CHECKSUM_EN
    ack_pct = 100;
    start_dl();
    send_word(25'h400000, 32'hFFFFFFFF, 0, 1'b1, 1'b1);
    send_word(25'h400004, 32'h00000002, 0, 1'b1, 1'b1);
    end_dl();
    check("checksum_wrap", {32'h0, checksum}, 64'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time limit expected $finish");
    $fatal(1, "watchdog expired");
  end
endmodule
